// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2
  } state_e;

  localparam int CNT_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: decode reads a register that the load in execute writes.
module load_use_detect (
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_ren,
  input  logic       rs2_ren,
  input  logic [4:0] rd_addr,
  input  logic       mem_read,
  output logic       hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_ren && (rs1_addr == rd_addr);
  assign rs2_hit = rs2_ren && (rs2_addr == rd_addr);
  // x0 is never written, so a load targeting it cannot create a dependency.
  assign hazard  = mem_read && (rd_addr != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall / bubble / flush sequencer for the 5-stage core: load-use, taken-branch squash
// and multi-cycle execute freeze with a watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id__rs1_addr,
  input  logic [4:0]       id__rs2_addr,
  input  logic             id__rs1_ren,
  input  logic             id__rs2_ren,
  input  logic [4:0]       id_ex__rd_addr,
  input  logic             id_ex__mem_read,
  input  logic             id_ex__mc_op,
  input  logic             ex__branch_taken,
  input  logic             mc_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mb_bubble,
  output logic             pipe_flush,
  output logic             mc_start,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WDW = $clog2(MC_TIMEOUT + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LIMIT   = WDW'(MC_TIMEOUT);

  state_e           state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;
  logic             hazard;
  logic             mc_release;

  load_use_detect u_load_use_detect (
    .rs1_addr (id__rs1_addr),
    .rs2_addr (id__rs2_addr),
    .rs1_ren  (id__rs1_ren),
    .rs2_ren  (id__rs2_ren),
    .rd_addr  (id_ex__rd_addr),
    .mem_read (id_ex__mem_read),
    .hazard   (hazard)
  );

  // Done wins over the watchdog when both land in the same cycle.
  assign mc_release = mc_done || (wd_q == WD_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    case (state_q)
      RUN: begin
        if (ex__branch_taken) begin
          flush_cnt_d = FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) state_d = FLUSH;
        end else if (id_ex__mc_op) begin
          wd_d    = '0;
          state_d = MC_WAIT;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q <= FCW'(1)) state_d = RUN;
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (wd_q == WD_LIMIT) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mb_bubble = 1'b0;
    pipe_flush   = 1'b0;
    mc_start     = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (ex__branch_taken) begin
            pipe_flush = 1'b1;
          end else if (id_ex__mc_op) begin
            mc_start     = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mb_bubble = 1'b1;
          end else if (hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        FLUSH: pipe_flush = 1'b1;
        MC_WAIT: begin
          // The release cycle drops every hold so EX/MB captures the result.
          if (!mc_release) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mb_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= sat_inc(stall_count_q, pc_stall);
      flush_count_q <= sat_inc(flush_count_q, pipe_flush);
    end
  end

  assign mc_timeout  = timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the 5-stage integer core; it sits beside the execute stage and sequences its stall, bubble and flush controls. It detects load-use hazards in decode and squashes wrong-path instructions after a taken branch resolved in execute. It also freezes the pipeline around multi-cycle execute operations (iterative mul/div) using a start/done handshake with a watchdog. It drives `pipe_flush` into execute and the stall/bubble enables of the PC, IF/ID, ID/EX and EX/MB registers.

## Interface
- `FLUSH_CYCLES`, 2: cycles `pipe_flush` stays high per taken branch (≥1).
- `MC_TIMEOUT`, 64: maximum MC_WAIT cycles before the watchdog fires (≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; **one clock; reset is asynchronous and active-high.**
- `id__rs1_addr`, `id__rs2_addr` in 5 each: decode-stage source registers.
- `id__rs1_ren`, `id__rs2_ren` in 1 each: decode instruction reads rs1 / rs2.
- `id_ex__rd_addr` in 5: execute-stage destination register.
- `id_ex__mem_read` in 1: the execute instruction is a load.
- `id_ex__mc_op` in 1: the execute instruction is multi-cycle.
- `ex__branch_taken` in 1: a branch or jump resolved taken in execute this cycle.
- `mc_done` in 1: the multi-cycle unit's result is valid this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall` out 1 each: hold register contents.
- `id_ex_bubble` out 1: load a NOP into ID/EX.
- `ex_mb_bubble` out 1: clear `rd_wen` and `mem_*` going into EX/MB.
- `pipe_flush` out 1: squash IF/ID and ID/EX; execute also uses it to poison `ex_mb__pc`.
- `mc_start` out 1: single-cycle start pulse to the multi-cycle unit.
- `mc_timeout` out 1: sticky watchdog error.
- `stall_count`, `flush_count` out 32 each: saturating performance counters.

## Operation
- States: RUN, FLUSH, MC_WAIT. Reset puts the FSM in RUN, zeroes both counters and clears `mc_timeout`.
- All control outputs are Mealy. While `rst` is high, every output is 0.
- Load-use hazard is `id_ex__mem_read && rd!=0 && ((rs1_ren && rs1==rd) || (rs2_ren && rs2==rd))`.
- In RUN, priority is branch > mc_op > load-use:
  - **branch:** assert `pipe_flush`, load the flush counter with FLUSH_CYCLES-1, go to FLUSH. If FLUSH_CYCLES==1, stay in RUN.
  - **mc_op:** pulse `mc_start`, assert all three stalls and `ex_mb_bubble`, clear the watchdog, go to MC_WAIT.
  - **load-use:** assert `pc_stall`, `if_id_stall` and `id_ex_bubble` for one cycle and stay in RUN. The bubble clears the hazard.
- FLUSH:
  - Assert `pipe_flush` and decrement the counter; return to RUN when the counter is 0.
  - Ignore `ex__branch_taken`, `id_ex__mc_op` and load-use (those instructions are squashed).
- MC_WAIT:
  - Assert all stalls and `ex_mb_bubble`; increment the watchdog.
  - On `mc_done`: deassert every stall and `ex_mb_bubble` in that cycle so EX/MB captures the result; return to RUN.
  - On watchdog == MC_TIMEOUT with no done: set `mc_timeout` and return to RUN the same way.
  - Ignore `ex__branch_taken` (EX is frozen).
- `mc_done` outside MC_WAIT, or in the same cycle as `mc_start`, is ignored.
- `stall_count` increments on every cycle with `pc_stall`; `flush_count` increments on every cycle with `pipe_flush`. Both saturate at 0xFFFFFFFF.

## Timing
- Hazard, branch and mc_op responses are combinational in the same cycle as the input.
- Branch: `pipe_flush` is high for exactly FLUSH_CYCLES consecutive cycles starting with the branch cycle.
- MC: stalls last from the `mc_start` cycle through the cycle before `mc_done`. Minimum stall is 1 cycle (done arriving the cycle after start).
- Watchdog: a timeout releases the stall after MC_TIMEOUT+1 stalled cycles. `mc_timeout` is visible from the following cycle.
- Reset asserted mid-MC_WAIT or mid-FLUSH: outputs go to 0 immediately and the FSM is in RUN on the first edge after release.

## Structure
- Package `pipe_ctrl_pkg` holds the state enum (RUN, FLUSH, MC_WAIT) and the counter width constant.
- Sub-module `load_use_detect` is the purely combinational hazard comparator, reusable by decode assertions.
- The FSM, flush counter, watchdog and performance counters live in `pipe_ctrl`.

## Test plan
- **Load-use:** rd=5 with mem_read, decode rs1=5 ren=1 → exactly one cycle of `pc_stall`/`if_id_stall`/`id_ex_bubble`, `stall_count`=1. Repeat with rd=0 → no stall.
- **Branch:** `ex__branch_taken` for 1 cycle with FLUSH_CYCLES=2 → `pipe_flush` high 2 cycles, `flush_count`=2. A second taken branch in cycle 2 is ignored.
- **Multi-cycle:** mc_op with `mc_done` 5 cycles later → `mc_start` is a 1-cycle pulse, stalls and `ex_mb_bubble` high 5 cycles, all low in the done cycle.
- **Priority:** branch, mc_op and load-use all true in one cycle → only `pipe_flush`, no `mc_start`, no stall.
- **Watchdog:** mc_op with no `mc_done`, MC_TIMEOUT=4 → stall released after 5 cycles, `mc_timeout`=1 until `rst`.
- **Async reset:** `rst` pulsed between edges in MC_WAIT → all outputs 0 immediately, counters 0, the next mc_op restarts cleanly.
